// File: rtl/yarvi_ib_if.sv
// Fetch/decode handshake bundle for the yarvi instruction buffer.
// The slave modport is the buffer; the master modport is the fetch/decode/execute side.
`ifndef VMSB
`define VMSB 31
`endif

interface yarvi_ib_if;
    logic              fe_valid;
    logic [`VMSB:0]    fe_pc;
    logic [31:0]       fe_insn;
    logic              fe_restart;
    logic [`VMSB:0]    fe_restart_pc;
    logic              flush;
    logic [`VMSB:0]    flush_pc;
    logic              ib_valid;
    logic [`VMSB:0]    ib_pc;
    logic [31:0]       ib_insn;
    logic              ib_ready;
    logic [31:0]       ib_replays;

    modport slave (
        input  fe_valid, fe_pc, fe_insn, flush, flush_pc, ib_ready,
        output fe_restart, fe_restart_pc, ib_valid, ib_pc, ib_insn, ib_replays
    );

    modport master (
        output fe_valid, fe_pc, fe_insn, flush, flush_pc, ib_ready,
        input  fe_restart, fe_restart_pc, ib_valid, ib_pc, ib_insn, ib_replays
    );
endinterface

// File: rtl/yarvi_ib.sv
// Instruction buffer between a free-running fetch and a stallable decode.
// Overflow drops the tail of the stream and replays fetch from the first dropped PC.
`ifndef VMSB
`define VMSB 31
`endif

module yarvi_ib #(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    yarvi_ib_if.slave    ib
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0]  ST_RUN   = 1'b0;
    localparam logic [0:0]  ST_DROP  = 1'b1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [`VMSB:0] mem_pc_q   [DEPTH];
    logic [31:0]    mem_insn_q [DEPTH];

    logic [0:0]     state_q, state_d;
    logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]    count_q, count_d;
    logic [`VMSB:0] replay_pc_q, replay_pc_d;
    logic [31:0]    replays_q, replays_d;

    logic           valid_s, pop_s, space_s, push_s, pop_en_s;
    logic           restart_s;
    logic [`VMSB:0] restart_pc_s;

    assign valid_s = (count_q != CNT_ZERO);
    assign pop_s   = valid_s & ib.ib_ready;
    assign space_s = (count_q < CNT_FULL) | pop_s;

    // Next-state logic: flush beats everything, then RUN/DROP handling.
    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        count_d      = count_q;
        replay_pc_d  = replay_pc_q;
        replays_d    = replays_q;
        restart_s    = 1'b0;
        restart_pc_s = replay_pc_q;
        push_s       = 1'b0;
        pop_en_s     = 1'b0;
        if (ib.flush) begin
            restart_s    = 1'b1;
            restart_pc_s = ib.flush_pc;
            count_d      = CNT_ZERO;
            rd_d         = wr_q;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    pop_en_s = pop_s;
                    push_s   = ib.fe_valid & space_s;
                    if (ib.fe_valid && !space_s) begin
                        replay_pc_d = ib.fe_pc;
                        state_d     = ST_DROP;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end
                ST_DROP: begin
                    // The fetch word in the restart cycle is stale; only the head may drain.
                    pop_en_s = pop_s;
                    if (space_s) begin
                        restart_s = 1'b1;
                        replays_d = replays_q + 32'd1;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
            wr_d    = push_s   ? wr_q + PTR_ONE : wr_q;
            rd_d    = pop_en_s ? rd_q + PTR_ONE : rd_q;
            count_d = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_en_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            rd_q        <= {AW{1'b0}};
            wr_q        <= {AW{1'b0}};
            count_q     <= CNT_ZERO;
            replay_pc_q <= {(`VMSB+1){1'b0}};
            replays_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            replay_pc_q <= replay_pc_d;
            replays_q   <= replays_d;
        end
    end

    // Queue storage; contents are don't-care until count covers them.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_pc_q[wr_q]   <= ib.fe_pc;
            mem_insn_q[wr_q] <= ib.fe_insn;
        end
    end

    assign ib.fe_restart    = restart_s;
    assign ib.fe_restart_pc = restart_pc_s;
    assign ib.ib_valid      = valid_s;
    assign ib.ib_pc         = valid_s ? mem_pc_q[rd_q]   : {(`VMSB+1){1'b0}};
    assign ib.ib_insn       = valid_s ? mem_insn_q[rd_q] : 32'd0;
    assign ib.ib_replays    = replays_q;
endmodule

// File: tb/tb_yarvi_ib.sv
// Directed bench for yarvi_ib: reset, streaming, overflow/replay, full push+pop,
// flush priority, pointer wrap and asynchronous reset.
`timescale 1ns/1ps

module tb_yarvi_ib;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    yarvi_ib_if bus ();

    yarvi_ib #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .ib    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, input logic [31:0] fpc);
        bus.fe_valid = v;
        bus.fe_pc    = pc;
        bus.fe_insn  = insn_of(pc);
        bus.ib_ready = rdy;
        bus.flush    = fl;
        bus.flush_pc = fpc;
        #1;
    endtask

    initial begin
        logic [31:0] exp_q [4];
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;

        // Reset with fetch active
        drv(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        tick; tick;
        chk("rst_valid",   {31'd0, bus.ib_valid}, 32'd0);
        chk("rst_pc",      bus.ib_pc, 32'h0);
        chk("rst_insn",    bus.ib_insn, 32'h0);
        chk("rst_replays", bus.ib_replays, 32'd0);
        chk("rst_restart", {31'd0, bus.fe_restart}, 32'd0);
        drv(1'b1, 32'h40, 1'b0, 1'b1, 32'h123);
        chk("rst_flush_restart", {31'd0, bus.fe_restart}, 32'd1);
        chk("rst_flush_pc",      bus.fe_restart_pc, 32'h123);
        tick;
        reset = 1'b0;

        // Streaming, no bypass
        drv(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        chk("str_nobypass", {31'd0, bus.ib_valid}, 32'd0);
        tick;
        drv(1'b1, 32'h104, 1'b1, 1'b0, 32'h0);
        chk("str_valid0", {31'd0, bus.ib_valid}, 32'd1);
        chk("str_pc0",    bus.ib_pc, 32'h100);
        chk("str_insn0",  bus.ib_insn, insn_of(32'h100));
        tick;
        drv(1'b1, 32'h108, 1'b1, 1'b0, 32'h0);
        chk("str_pc1", bus.ib_pc, 32'h104);
        tick;
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("str_pc2", bus.ib_pc, 32'h108);
        tick;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("str_empty", {31'd0, bus.ib_valid}, 32'd0);
        tick;

        // Overflow and replay
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            tick;
        end
        drv(1'b1, 32'h110, 1'b0, 1'b0, 32'h0);
        chk("ov_drop_norestart", {31'd0, bus.fe_restart}, 32'd0);
        tick;
        drv(1'b1, 32'h114, 1'b0, 1'b0, 32'h0);
        chk("ov_hold_restart", {31'd0, bus.fe_restart}, 32'd0);
        chk("ov_hold_rpc",     bus.fe_restart_pc, 32'h110);
        chk("ov_hold_head",    bus.ib_pc, 32'h100);
        tick;
        drv(1'b1, 32'h118, 1'b1, 1'b0, 32'h0);
        chk("ov_restart",    {31'd0, bus.fe_restart}, 32'd1);
        chk("ov_restart_pc", bus.fe_restart_pc, 32'h110);
        chk("ov_head",       bus.ib_pc, 32'h100);
        chk("ov_replays0",   bus.ib_replays, 32'd0);
        tick;
        drv(1'b1, 32'h110, 1'b0, 1'b0, 32'h0);
        chk("ov_replays1", bus.ib_replays, 32'd1);
        chk("ov_head1",    bus.ib_pc, 32'h104);
        chk("ov_run",      {31'd0, bus.fe_restart}, 32'd0);
        tick;
        drv(1'b1, 32'h114, 1'b1, 1'b0, 32'h0);
        chk("ov_full_pp_head",    bus.ib_pc, 32'h104);
        chk("ov_full_pp_restart", {31'd0, bus.fe_restart}, 32'd0);
        tick;
        exp_q = '{32'h108, 32'h10C, 32'h110, 32'h114};
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk("ov_drain_pc", bus.ib_pc, exp_q[i]);
            tick;
        end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("ov_drain_empty", {31'd0, bus.ib_valid}, 32'd0);
        tick;

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h1F0 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            tick;
        end
        drv(1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        chk("pp_restart", {31'd0, bus.fe_restart}, 32'd0);
        chk("pp_head",    bus.ib_pc, 32'h1F0);
        tick;
        exp_q = '{32'h1F4, 32'h1F8, 32'h1FC, 32'h200};
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk("pp_no_drop", {31'd0, bus.fe_restart}, 32'd0);
            chk("pp_drain_pc", bus.ib_pc, exp_q[i]);
            tick;
        end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("pp_empty", {31'd0, bus.ib_valid}, 32'd0);
        tick;

        // Flush while in DROP with decode also ready
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            tick;
        end
        drv(1'b1, 32'h310, 1'b0, 1'b0, 32'h0);
        tick;
        drv(1'b1, 32'h314, 1'b1, 1'b1, 32'h800);
        chk("fl_restart",    {31'd0, bus.fe_restart}, 32'd1);
        chk("fl_restart_pc", bus.fe_restart_pc, 32'h800);
        tick;
        drv(1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        chk("fl_empty",   {31'd0, bus.ib_valid}, 32'd0);
        chk("fl_pc_zero", bus.ib_pc, 32'h0);
        chk("fl_run",     {31'd0, bus.fe_restart}, 32'd0);
        chk("fl_replays", bus.ib_replays, 32'd1);
        tick;
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("fl_new_head", bus.ib_pc, 32'h800);
        chk("fl_new_insn", bus.ib_insn, insn_of(32'h800));
        tick;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("fl_drained", {31'd0, bus.ib_valid}, 32'd0);
        tick;

        // Pointer wrap: push on even cycles, pop on odd cycles, 10 instructions
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) begin
                drv(1'b1, 32'h900 + 32'(4 * (k / 2)), 1'b0, 1'b0, 32'h0);
                chk("wr_empty", {31'd0, bus.ib_valid}, 32'd0);
            end else begin
                drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
                chk("wr_pc", bus.ib_pc, 32'h900 + 32'(4 * ((k - 1) / 2)));
            end
            tick;
        end

        // Asynchronous reset mid-operation
        drv(1'b1, 32'hA00, 1'b0, 1'b0, 32'h0);
        tick;
        drv(1'b1, 32'hA04, 1'b0, 1'b0, 32'h0);
        chk("ar_before", bus.ib_pc, 32'hA00);
        tick;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid",   {31'd0, bus.ib_valid}, 32'd0);
        chk("ar_pc",      bus.ib_pc, 32'h0);
        chk("ar_replays", bus.ib_replays, 32'd0);
        tick;
        reset = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick;
        chk("ar_after", {31'd0, bus.ib_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
